// File: rtl/trans_cu.sv
// Transmit control unit: queues 16-bit FIR results and sends each one to the
// UART transmitter as two bytes, MSB first, using the start/busy handshake.
module trans_cu #(
    parameter int DEPTH_LOG2 = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        fir_done,
    input  logic [15:0] fir_out,
    input  logic        TxD_busy,
    output logic        TxD_start,
    output logic [7:0]  TxD_data,
    output logic        fifo_empty,
    output logic        fifo_full,
    output logic        overflow
);
    localparam int DEPTH = 1 << DEPTH_LOG2;

    typedef enum logic [2:0] {IDLE, SEND_MSB, WAIT_MSB, SEND_LSB, WAIT_LSB} state_t;

    state_t                state, state_nx;
    logic [15:0]           mem [DEPTH];
    logic [DEPTH_LOG2-1:0] wr_ptr, rd_ptr;
    logic [DEPTH_LOG2:0]   count;
    logic [15:0]           hold, hold_nx;
    logic                  start_nx;
    logic [7:0]            data_nx;
    logic                  push, pop;

    assign fifo_empty = (count == '0);
    assign fifo_full  = (count == DEPTH[DEPTH_LOG2:0]);
    // full is judged before any pop this cycle, so a same-cycle pop never makes room
    assign push       = fir_done && !fifo_full;

    always_comb begin
        state_nx = state;
        start_nx = 1'b0;
        data_nx  = TxD_data;
        hold_nx  = hold;
        pop      = 1'b0;
        case (state)
            IDLE: begin
                if (!fifo_empty && !TxD_busy) begin
                    pop      = 1'b1;
                    hold_nx  = mem[rd_ptr];
                    start_nx = 1'b1;
                    data_nx  = mem[rd_ptr][15:8];
                    state_nx = SEND_MSB;
                end
            end
            SEND_MSB: state_nx = WAIT_MSB;
            WAIT_MSB: begin
                if (!TxD_busy) begin
                    start_nx = 1'b1;
                    data_nx  = hold[7:0];
                    state_nx = SEND_LSB;
                end
            end
            SEND_LSB: state_nx = WAIT_LSB;
            WAIT_LSB: if (!TxD_busy) state_nx = IDLE;
            default:  state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= IDLE;
            TxD_start <= 1'b0;
            TxD_data  <= 8'h00;
            hold      <= 16'h0000;
        end else begin
            state     <= state_nx;
            TxD_start <= start_nx;
            TxD_data  <= data_nx;
            hold      <= hold_nx;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            overflow <= 1'b0;
        end else begin
            if (push) wr_ptr <= wr_ptr + DEPTH_LOG2'(1);
            if (pop)  rd_ptr <= rd_ptr + DEPTH_LOG2'(1);
            case ({push, pop})
                2'b10:   count <= count + (DEPTH_LOG2+1)'(1);
                2'b01:   count <= count - (DEPTH_LOG2+1)'(1);
                default: count <= count;
            endcase
            if (fir_done && fifo_full) overflow <= 1'b1;
        end
    end

    // storage needs no reset: pointers and count define what is valid
    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= fir_out;
    end
endmodule

// File: doc/trans_cu.md
Name: trans_cu

Overview:
- Transmit-side control unit: the return path from the FIR filter back to the UART transmitter.
- Buffers 16-bit FIR results in a small FIFO.
- Serializes each result as two bytes, MSB first then LSB, using the UART TX start/busy handshake.
- Byte order is the mirror of the receive path (MSB byte, then LSB byte), so the host sees the same framing in both directions.

Parameters:
- DEPTH_LOG2, 2, log2 of FIFO depth in 16-bit words. Default depth is 4. Legal range 1..4.

Ports:
- clk  input  1  system clock; all logic on the rising edge.
- rst  input  1  asynchronous, active-low reset. 0 resets the block immediately; release is synchronous to clk.
- fir_done  input  1  one-cycle strobe; fir_out is valid in that cycle.
- fir_out  input  16  FIR result word.
- TxD_busy  input  1  UART TX busy. It rises on the clk edge that samples TxD_start=1 and stays high until the byte is fully shifted out.
- TxD_start  output  1  registered one-cycle pulse requesting transmission of TxD_data.
- TxD_data  output  8  registered byte to transmit. Stable from the TxD_start cycle until the next TxD_start.
- fifo_empty  output  1  FIFO holds 0 words.
- fifo_full  output  1  FIFO holds 2^DEPTH_LOG2 words.
- overflow  output  1  sticky flag: a fir_done arrived while the FIFO was full.

Behaviour:
- Reset values (rst=0, asynchronous):
  - TxD_start=0, TxD_data=8'h00.
  - fifo_empty=1, fifo_full=0, overflow=0.
  - Pointers and count = 0; FSM = IDLE.
  - Any word in flight is discarded.
- FIFO:
  - Circular buffer with separate write/read pointers, each DEPTH_LOG2 bits wide and wrapping naturally.
  - Count register is DEPTH_LOG2+1 bits.
  - Push on fir_done when not full.
  - fir_done while full: word dropped, overflow set to 1. overflow clears only on reset.
  - Full is judged on the count at the start of the cycle. A pop in the same cycle does not make room; that push is still dropped.
  - Simultaneous push (not full) and pop: count unchanged, both pointers advance.
  - fifo_empty and fifo_full are combinational from count.
- FSM states:
  - IDLE:
    - If !fifo_empty and !TxD_busy: pop the head word into a 16-bit hold register, go to SEND_MSB.
    - Otherwise stay.
  - SEND_MSB: TxD_start=1 and TxD_data=hold[15:8] for exactly this cycle. Go to WAIT_MSB.
  - WAIT_MSB: TxD_start=0. Stay while TxD_busy=1; on TxD_busy=0 go to SEND_LSB.
  - SEND_LSB: TxD_start=1, TxD_data=hold[7:0]. Go to WAIT_LSB.
  - WAIT_LSB: stay while TxD_busy=1; on TxD_busy=0 go to IDLE.
  - Unused encodings go to IDLE.
- Latency:
  - Push at edge N with FIFO empty and FSM idle → fifo_empty=0 in cycle N+1.
  - Pop at edge N+1 → TxD_start=1 with the MSB during cycle N+2.
  - LSB TxD_start occurs 1 cycle after TxD_busy is first seen low in WAIT_MSB.
  - Back-to-back words: IDLE inserts exactly 1 cycle between LSB-busy-low and the next pop.
- TxD_start is never high in two consecutive cycles. It is never asserted while TxD_busy=1 as seen in IDLE.
- The hold register captures the word at pop. Later FIFO pushes do not alter a word being sent.
- Reset mid-word (e.g. in WAIT_MSB): outputs return to reset values immediately. After release, no LSB is sent for the aborted word.

Test Plan:
- Single word: reset, fir_done with fir_out=16'hA55A. Model TX busy for 10 cycles after each start. Required: TxD_start pulse with TxD_data=8'hA5 2 cycles after the strobe; after busy falls, a pulse with 8'h5A; exactly 2 pulses total; fifo_empty=1 at end.
- Burst fill: 4 consecutive fir_done strobes (16'h0102, 16'h0304, 16'h0506, 16'h0708) while TxD_busy is held 1. Required: fifo_full=1 after the 4th, overflow=0. Release busy: bytes 01,02,03,04,05,06,07,08 in order.
- Overflow: with the FIFO full and busy held, a 5th fir_done with 16'hFFFF. Required: overflow=1 and stays 1. 16'hFFFF is never transmitted. Count stays 4.
- Simultaneous push/pop: in the cycle IDLE pops with count=2, assert fir_done with 16'h1234. Required: count stays 2, and 12/34 is sent after the earlier words.
- Reset mid-word: assert rst=0 during WAIT_MSB of 16'hBEEF. Required: TxD_start=0, fifo_empty=1, overflow=0 without waiting for a clk edge. After release, no 8'hEF is ever sent.
- Busy handshake: keep TxD_busy=1 while the FSM is in IDLE with data queued. Required: no TxD_start until busy=0; then MSB start 1 cycle later.
